// File: rtl/id_sb_pkg.sv
// id_sb_pkg
//   Shared definitions for the decode stage with scoreboard:
//   - bank_e       : register bank encoding (integer / floating point)
//   - *_LSB        : bit positions of the register fields in an instruction
//   - id_ctrl_t    : width-independent part of the ID/EX payload
//   - reg_field()  : extracts a 5-bit register field from an instruction
package id_sb_pkg;

  typedef enum logic [0:0] {
    BANK_INT = 1'b0,
    BANK_FP  = 1'b1
  } bank_e;

  localparam int RS1_LSB     = 15;
  localparam int RS2_LSB     = 20;
  localparam int RD_LSB      = 7;
  localparam int REG_FIELD_W = 5;

  // Payload fields whose width does not depend on the stage parameters.
  typedef struct packed {
    logic [31:0] instr;
    logic        rd_we;
  } id_ctrl_t;

  function automatic logic [REG_FIELD_W-1:0] reg_field(input logic [31:0] instr,
                                                       input int          lsb);
    return instr[lsb +: REG_FIELD_W];
  endfunction

endpackage

// File: rtl/id_stage_sb_regfile.sv
// banked_regfile
//   NBANK x NREG register file, two combinational read ports and one
//   write port. Bank 0 register 0 is hard-wired to zero: it always reads 0
//   and writes to it are dropped. With WB_BYPASS=1 a write in flight this
//   cycle is forwarded to a read port addressing the same register.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   rd_bank_a/rd_idx_a       read port A address, rd_data_a data
//   rd_bank_b/rd_idx_b       read port B address, rd_data_b data
//   wr_en/wr_bank/wr_idx     write strobe and address
//   wr_data                  write data
module banked_regfile
  import id_sb_pkg::*;
#(
  parameter int NBANK     = 2,
  parameter int NREG      = 32,
  parameter int XLEN      = 32,
  parameter int WB_BYPASS = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [((NBANK > 1) ? $clog2(NBANK) : 1)-1:0] rd_bank_a,
  input  logic [$clog2(NREG)-1:0]                     rd_idx_a,
  output logic [XLEN-1:0]                             rd_data_a,
  input  logic [((NBANK > 1) ? $clog2(NBANK) : 1)-1:0] rd_bank_b,
  input  logic [$clog2(NREG)-1:0]                     rd_idx_b,
  output logic [XLEN-1:0]                             rd_data_b,
  input  logic                                        wr_en,
  input  logic [((NBANK > 1) ? $clog2(NBANK) : 1)-1:0] wr_bank,
  input  logic [$clog2(NREG)-1:0]                     wr_idx,
  input  logic [XLEN-1:0]                             wr_data
);

  localparam int RW = $clog2(NREG);
  localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;

  logic [XLEN-1:0] mem [NBANK][NREG];

  function automatic logic is_zero_reg(input logic [BW-1:0] bank,
                                       input logic [RW-1:0] idx);
    return (bank == BW'(BANK_INT)) && (idx == '0);
  endfunction

  // Storage. Register contents are cleared by reset; the zero register
  // slot is never written so it stays 0 for its whole life.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < NBANK; b++) begin
        for (int r = 0; r < NREG; r++) begin
          mem[b][r] <= '0;
        end
      end
    end else if (wr_en && !is_zero_reg(wr_bank, wr_idx)) begin
      mem[wr_bank][wr_idx] <= wr_data;
    end
  end

  // Read port A: forwarded write data wins over storage, the zero
  // register wins over both so a write to x0 can never leak through.
  always_comb begin
    rd_data_a = mem[rd_bank_a][rd_idx_a];
    if ((WB_BYPASS != 0) && wr_en && (wr_bank == rd_bank_a) && (wr_idx == rd_idx_a)) begin
      rd_data_a = wr_data;
    end
    if (is_zero_reg(rd_bank_a, rd_idx_a)) begin
      rd_data_a = '0;
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    rd_data_b = mem[rd_bank_b][rd_idx_b];
    if ((WB_BYPASS != 0) && wr_en && (wr_bank == rd_bank_b) && (wr_idx == rd_idx_b)) begin
      rd_data_b = wr_data;
    end
    if (is_zero_reg(rd_bank_b, rd_idx_b)) begin
      rd_data_b = '0;
    end
  end

endmodule

// File: rtl/id_stage_sb.sv
// id_stage_sb
//   Decode stage between IF and EX: banked register file read, a
//   per-register pending-write scoreboard, and a one-entry ID/EX output
//   register with valid/ready handshake.
//
// Ports:
//   clk, rst                   clock (rising edge), async active-low reset
//   if_valid/id_ready          fetch handshake; id_ready stalls IF
//   if_pc, if_instr            fetched PC and instruction word
//   dec_*                      operand-use / write flags and bank selects
//   wb_valid/bank/rd/data      writeback (register write, counter release)
//   kill_valid/bank/rd         squashed writer that will never write back
//   flush                      discard the ID/EX entry this cycle
//   id_valid/ex_ready          ID/EX handshake
//   id_pc ... id_rd_we         registered ID/EX payload
module id_stage_sb
  import id_sb_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int NBANK     = 2,
  parameter int SB_W      = 2,
  parameter int WB_BYPASS = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        if_valid,
  output logic                                        id_ready,
  input  logic [XLEN-1:0]                             if_pc,
  input  logic [31:0]                                 if_instr,
  input  logic                                        dec_rs1_use,
  input  logic                                        dec_rs2_use,
  input  logic                                        dec_rd_we,
  input  logic [((NBANK > 1) ? $clog2(NBANK) : 1)-1:0] dec_rs1_bank,
  input  logic [((NBANK > 1) ? $clog2(NBANK) : 1)-1:0] dec_rs2_bank,
  input  logic [((NBANK > 1) ? $clog2(NBANK) : 1)-1:0] dec_rd_bank,
  input  logic                                        wb_valid,
  input  logic [((NBANK > 1) ? $clog2(NBANK) : 1)-1:0] wb_bank,
  input  logic [$clog2(NREG)-1:0]                     wb_rd,
  input  logic [XLEN-1:0]                             wb_data,
  input  logic                                        kill_valid,
  input  logic [((NBANK > 1) ? $clog2(NBANK) : 1)-1:0] kill_bank,
  input  logic [$clog2(NREG)-1:0]                     kill_rd,
  input  logic                                        flush,
  output logic                                        id_valid,
  input  logic                                        ex_ready,
  output logic [XLEN-1:0]                             id_pc,
  output logic [31:0]                                 id_instr,
  output logic [XLEN-1:0]                             id_rs1_data,
  output logic [XLEN-1:0]                             id_rs2_data,
  output logic [$clog2(NREG)-1:0]                     id_rd,
  output logic [((NBANK > 1) ? $clog2(NBANK) : 1)-1:0] id_rd_bank,
  output logic                                        id_rd_we
);

  localparam int RW = $clog2(NREG);
  localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam logic [SB_W-1:0] CNT_MAX = '1;
  localparam logic [SB_W-1:0] CNT_ONE = SB_W'(1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [RW-1:0]   rd;
    logic [BW-1:0]   rd_bank;
    id_ctrl_t        ctrl;
  } id_payload_t;

  logic [RW-1:0]   rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [SB_W-1:0] cnt      [NBANK][NREG];
  logic [SB_W-1:0] cnt_next [NBANK][NREG];
  logic [SB_W-1:0] rs1_cnt, rs2_cnt, rd_cnt;
  logic            rs1_wb_hit, rs2_wb_hit;
  logic            hazard, rd_sat;
  logic            accept, handoff, drop;
  logic            id_valid_q;
  id_payload_t     id_q, id_d;

  function automatic logic reg_match(input logic [BW-1:0] bank,
                                     input logic [RW-1:0] idx,
                                     input int            b,
                                     input int            r);
    return (bank == BW'(b)) && (idx == RW'(r));
  endfunction

  assign rs1_idx = RW'(reg_field(if_instr, RS1_LSB));
  assign rs2_idx = RW'(reg_field(if_instr, RS2_LSB));
  assign rd_idx  = RW'(reg_field(if_instr, RD_LSB));

  banked_regfile #(
    .NBANK     (NBANK),
    .NREG      (NREG),
    .XLEN      (XLEN),
    .WB_BYPASS (WB_BYPASS)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_bank_a (dec_rs1_bank),
    .rd_idx_a  (rs1_idx),
    .rd_data_a (rs1_data),
    .rd_bank_b (dec_rs2_bank),
    .rd_idx_b  (rs2_idx),
    .rd_data_b (rs2_data),
    .wr_en     (wb_valid),
    .wr_bank   (wb_bank),
    .wr_idx    (wb_rd),
    .wr_data   (wb_data)
  );

  assign rs1_cnt = cnt[dec_rs1_bank][rs1_idx];
  assign rs2_cnt = cnt[dec_rs2_bank][rs2_idx];
  assign rd_cnt  = cnt[dec_rd_bank][rd_idx];

  // A source with exactly one pending writer that is writing back right
  // now is already resolved when bypass is enabled; with more than one
  // pending writer the value on the writeback bus is not the final one.
  assign rs1_wb_hit = (WB_BYPASS != 0) && wb_valid && (wb_bank == dec_rs1_bank) &&
                      (wb_rd == rs1_idx) && (rs1_cnt == CNT_ONE);
  assign rs2_wb_hit = (WB_BYPASS != 0) && wb_valid && (wb_bank == dec_rs2_bank) &&
                      (wb_rd == rs2_idx) && (rs2_cnt == CNT_ONE);

  assign hazard = (dec_rs1_use && (rs1_cnt != '0) && !rs1_wb_hit) ||
                  (dec_rs2_use && (rs2_cnt != '0) && !rs2_wb_hit);

  // A saturated counter cannot take another writer; a writeback in the
  // same cycle is deliberately not considered, the writer retries next cycle.
  assign rd_sat = dec_rd_we && (rd_cnt == CNT_MAX);

  assign id_ready = !flush && !hazard && !rd_sat && (!id_valid_q || ex_ready);
  assign accept   = if_valid && id_ready;
  assign handoff  = id_valid_q && ex_ready && !flush;
  assign drop     = flush && id_valid_q && id_q.ctrl.rd_we;

  // Scoreboard next state. Increment, writeback, kill and flush-drop can
  // all hit the same register in one cycle, so each is applied as an
  // independent +/-1 term. The zero register is never tracked.
  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_next[b][r] = cnt[b][r];
        if (!((b == int'(BANK_INT)) && (r == 0))) begin
          cnt_next[b][r] = cnt[b][r]
                         + SB_W'(accept && dec_rd_we && reg_match(dec_rd_bank, rd_idx, b, r))
                         - SB_W'(wb_valid && reg_match(wb_bank, wb_rd, b, r))
                         - SB_W'(kill_valid && reg_match(kill_bank, kill_rd, b, r))
                         - SB_W'(drop && reg_match(id_q.rd_bank, id_q.rd, b, r));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < NBANK; b++) begin
        for (int r = 0; r < NREG; r++) begin
          cnt[b][r] <= '0;
        end
      end
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        for (int r = 0; r < NREG; r++) begin
          cnt[b][r] <= cnt_next[b][r];
        end
      end
    end
  end

  // Payload captured on accept.
  always_comb begin
    id_d              = '0;
    id_d.pc           = if_pc;
    id_d.rs1_data     = rs1_data;
    id_d.rs2_data     = rs2_data;
    id_d.rd           = rd_idx;
    id_d.rd_bank      = dec_rd_bank;
    id_d.ctrl.instr   = if_instr;
    id_d.ctrl.rd_we   = dec_rd_we;
  end

  // Flush beats everything; otherwise a new accept refills the entry and a
  // plain hand-off empties it. With neither, the entry simply holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid_q <= 1'b0;
    end else if (flush) begin
      id_valid_q <= 1'b0;
    end else if (accept) begin
      id_valid_q <= 1'b1;
    end else if (handoff) begin
      id_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_q <= '0;
    end else if (accept) begin
      id_q <= id_d;
    end
  end

  assign id_valid    = id_valid_q;
  assign id_pc       = id_q.pc;
  assign id_instr    = id_q.ctrl.instr;
  assign id_rs1_data = id_q.rs1_data;
  assign id_rs2_data = id_q.rs2_data;
  assign id_rd       = id_q.rd;
  assign id_rd_bank  = id_q.rd_bank;
  assign id_rd_we    = id_q.ctrl.rd_we;

endmodule

// File: doc/id_stage_sb.md
Name: id_stage_sb

Overview:
Parametrised successor decode stage: banked register file (integer + FP banks), per-register pending-write scoreboard, and a one-entry ID/EX output register with valid/ready handshake.
- Sits between IF and EX; consumes fetch output plus decoded operand-use flags from the existing combinational decoder.
- Stalls IF on RAW hazards or counter saturation.
- Supports pipeline flush and kill of squashed in-flight writes.

Parameters:
XLEN, 32, data/PC width
NREG, 32, registers per bank (index width RW = clog2(NREG))
NBANK, 2, register banks (0 = integer, 1 = FP); bank index width BW = max(1, clog2(NBANK))
SB_W, 2, pending-write counter width per register
WB_BYPASS, 1, 1 = same-cycle writeback forwarded to read data and clears hazard

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
if_valid  in  1  fetch output valid
id_ready  out  1  ID accepts fetch output this cycle
if_pc  in  XLEN  instruction PC
if_instr  in  32  instruction word; rs1=[19:15], rs2=[24:20], rd=[11:7]
dec_rs1_use, dec_rs2_use, dec_rd_we  in  1 each  operand-use / write flags from decoder
dec_rs1_bank, dec_rs2_bank, dec_rd_bank  in  BW each  bank selects
wb_valid  in  1  writeback strobe
wb_bank  in  BW  writeback bank
wb_rd  in  RW  writeback index
wb_data  in  XLEN  writeback data
kill_valid  in  1  squashed in-flight writer (never writes back)
kill_bank  in  BW  bank of squashed writer
kill_rd  in  RW  index of squashed writer
flush  in  1  discard ID contents
id_valid  out  1  ID/EX entry valid
ex_ready  in  1  EX accepts entry
id_pc  out  XLEN  registered PC
id_instr  out  32  registered instruction
id_rs1_data, id_rs2_data  out  XLEN each  registered operands
id_rd  out  RW  registered destination index
id_rd_bank  out  BW  registered destination bank
id_rd_we  out  1  registered destination write flag

Behaviour:
Register file:
- Reads are combinational. Writes on clk when wb_valid.
- Bank 0 reg 0 reads 0 and is never written or tracked.

Scoreboard:
- One SB_W-bit count per (bank, reg).
- hazard = (dec_rs1_use and cnt[rs1] != 0) or (dec_rs2_use and cnt[rs2] != 0).
- With WB_BYPASS=1: a source whose cnt == 1 and matches wb_valid/wb_bank/wb_rd this cycle is not hazardous; its data is taken from wb_data.

Handshake:
- id_ready = not flush and not hazard and not (dec_rd_we and cnt[rd] == max) and (not id_valid or ex_ready).
- Accept (if_valid and id_ready) loads the output register next edge and sets id_valid.
- Hand-off (id_valid and ex_ready and not flush) without accept clears id_valid.
- Outputs hold while id_valid and not ex_ready.

Counter update, per register, in one cycle:
- next = cnt + inc − dec_wb − dec_kill − dec_drop.
- inc: accept with dec_rd_we on that register.
- dec_drop: flush while the output entry is valid with id_rd_we on that register.
- All terms apply in the same cycle. Up to three decrements can coincide.
- Underflow never happens with legal stimulus. A bench assertion flags it.

Flush:
- Takes precedence over hand-off: no hand-off and no accept that cycle.
- id_valid clears next edge.

Writes and kills to bank 0 reg 0: ignored.

Latency:
- 1 cycle fetch to id_valid.
- With WB_BYPASS=0, a consumer issues the cycle after writeback.

Reset (rst low, asynchronous):
- All counters, register contents, and output-register fields clear to 0.
- id_valid = 0. Reset mid-stall discards everything.
- id_ready may assert combinationally after release.

Decomposition:
- Package id_sb_pkg: bank enum (BANK_INT=0, BANK_FP=1), field-slice constants (RS1_LSB, RS2_LSB, RD_LSB), ID/EX payload struct.
- Sub-module banked_regfile (parameters NBANK, NREG, XLEN, WB_BYPASS): 2 read ports, 1 write port, zero-register rule.
- Scoreboard and output register stay in id_stage_sb.

Test Plan:
1. RAW stall: issue write x5 (ex_ready=1), next instruction reads x5 → id_ready=0 until wb_valid rd=5. That cycle id_ready=1 and id_rs1_data=wb_data=0xDEADBEEF (WB_BYPASS=1). With WB_BYPASS=0, id_ready=1 one cycle later.
2. Bank separation: pending write f5 (bank 1), reader of x5 (bank 0) → no stall. Reader of f5 with dec_rs2_bank=1 → stalls.
3. Flush: entry valid writing x7, ex_ready=0, flush=1 → id_valid=0 next cycle, cnt[x7] returns to 0, reader of x7 issues immediately. Simultaneous if_valid is not accepted.
4. Saturation (SB_W=2): three accepted writes to x3 with no writeback → cnt=3; fourth writer gets id_ready=0. One wb rd=3 → it issues.
5. Simultaneous events: wb, kill, and flush-drop all on x9 with cnt=3 in one cycle → cnt=0. Accept of a new x9 writer plus wb x9 in the same cycle → cnt unchanged.
6. Zero register and reset: wb to x0 with 0x1 → reads x0 = 0, no stall on x0. Assert rst low mid-stall → id_valid=0 immediately, x1 reads 0 after release.
